// File: rtl/dvp_gray_scale.sv
// RGB565 to 8-bit luminance converter: two-stage valid/ready pipeline plus a delivered-pixel counter.
// Define DVP_GRAY_SCALE_ROUND_EN to round to nearest instead of truncating.
module dvp_gray_scale #(
  parameter int unsigned RGB_PXL_W = 16,
  parameter int unsigned GS_PXL_W  = 8,
  parameter int unsigned CNT_W     = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RGB_PXL_W-1:0] rgb_pxl_i,
  input  logic                 rgb_pxl_vld_i,
  output logic                 rgb_pxl_rdy_o,
  output logic [GS_PXL_W-1:0]  gs_pxl_o,
  output logic                 gs_pxl_vld_o,
  input  logic                 gs_pxl_rdy_i,
  input  logic                 cnt_clr_i,
  output logic [CNT_W-1:0]     gs_pxl_cnt_o
);

`ifdef DVP_GRAY_SCALE_ROUND_EN
  localparam logic [15:0] RND = 16'd128;
`else
  localparam logic [15:0] RND = 16'd0;
`endif

  logic [7:0]  r8, g8, b8;
  logic [15:0] p_r, p_g, p_b;
  logic [15:0] sum;
  logic        s1_vld;
  logic        s1_load, s2_load;
  logic        in_xfer, out_xfer;

  always_comb begin
    r8       = {rgb_pxl_i[15:11], rgb_pxl_i[15:13]};
    g8       = {rgb_pxl_i[10:5],  rgb_pxl_i[10:9]};
    b8       = {rgb_pxl_i[4:0],   rgb_pxl_i[4:2]};
    sum      = p_r + p_g + p_b + RND;
    s2_load  = !gs_pxl_vld_o || gs_pxl_rdy_i;
    s1_load  = !s1_vld || s2_load;
    // Equivalent to !s1_vld | !s2_vld | gs_pxl_rdy_i; independent of rgb_pxl_vld_i.
    rgb_pxl_rdy_o = s1_load;
    in_xfer  = rgb_pxl_vld_i && rgb_pxl_rdy_o;
    out_xfer = gs_pxl_vld_o && gs_pxl_rdy_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      p_r    <= '0;
      p_g    <= '0;
      p_b    <= '0;
    end else if (s1_load) begin
      s1_vld <= in_xfer;
      if (in_xfer) begin
        p_r <= 16'd77  * {8'd0, r8};
        p_g <= 16'd150 * {8'd0, g8};
        p_b <= 16'd29  * {8'd0, b8};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gs_pxl_vld_o <= 1'b0;
      gs_pxl_o     <= '0;
    end else if (s2_load) begin
      gs_pxl_vld_o <= s1_vld;
      if (s1_vld) begin
        gs_pxl_o <= sum[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gs_pxl_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      gs_pxl_cnt_o <= '0;
    end else if (out_xfer) begin
      gs_pxl_cnt_o <= gs_pxl_cnt_o + CNT_W'(1);
    end
  end

endmodule
